// File: rtl/io_uart_in.sv
// Memory-mapped 8N1 UART receiver on the dma_io bus with a byte FIFO and interrupt outputs.
// Optional parity checking is compiled in when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module io_uart_in #(
    parameter logic [13:0] BASE_ADR   = 14'h0300,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic        dma_io_we,
    input  logic [13:0] dma_io_wadr,
    input  logic [31:0] dma_io_wdata,
    input  logic [13:0] dma_io_radr,
    input  logic        dma_io_radr_en,
    input  logic [31:0] dma_io_rdata_in,
    output logic [31:0] dma_io_rdata,
    output logic        rx_interrupt_1shot,
    output logic        rx_irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0, ST_START = 3'd1, ST_DATA = 3'd2, ST_STOP = 3'd3, ST_PARITY = 3'd4
    } rx_state_t;

    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction
`else
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0, ST_START = 3'd1, ST_DATA = 3'd2, ST_STOP = 3'd3
    } rx_state_t;
`endif

    logic            rx_meta_r, rx_sync_r, rx_prev_r;
    rx_state_t       state_r;
    logic [15:0]     cnt_r, div_r, div_lat_r, div_eff_s;
    logic [2:0]      bit_idx_r;
    logic [7:0]      shift_r;
    logic            ctrl_en_r, ctrl_ie_r, ovr_r, ferr_r, perr_s, par_err_s;
    logic [7:0]      mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            hit_r, irq_1shot_r;
    logic [31:0]     rdata_r, rd_val_s;
    logic [13:0]     rd_off_s;
    logic            fall_s, stop_s, frame_ok_s, ferr_set_s, perr_set_s, ctrl_wr_s, div_wr_s;
    logic            flush_s, clr_s, hit_s, empty_s, full_s, pop_s, push_s, ovr_set_s;
    logic [3:2]      ctrl_par_s;
`ifdef UART_RX_PARITY_EN
    logic            ctrl_pen_r, ctrl_odd_r, par_err_r, perr_r;
    assign par_err_s  = par_err_r;
    assign perr_s     = perr_r;
    assign ctrl_par_s = {ctrl_odd_r, ctrl_pen_r};
`else
    assign par_err_s  = 1'b0;
    assign perr_s     = 1'b0;
    assign ctrl_par_s = 2'b00;
`endif

    assign div_eff_s  = (div_r < 16'd4) ? 16'd4 : div_r;
    assign fall_s     = rx_prev_r & ~rx_sync_r;
    assign stop_s     = ctrl_en_r && (state_r == ST_STOP) && (cnt_r == 16'd0);
    assign frame_ok_s = stop_s & rx_sync_r & ~par_err_s;
    assign ferr_set_s = stop_s & ~rx_sync_r;
    assign perr_set_s = stop_s & par_err_s;
    assign ctrl_wr_s  = dma_io_we && (dma_io_wadr == BASE_ADR + 14'd2);
    assign div_wr_s   = dma_io_we && (dma_io_wadr == BASE_ADR + 14'd3);
    assign flush_s    = ctrl_wr_s & dma_io_wdata[9];
    assign clr_s      = ctrl_wr_s & dma_io_wdata[8];
    assign rd_off_s   = dma_io_radr - BASE_ADR;
    assign hit_s      = dma_io_radr_en && (rd_off_s < 14'd4);
    assign empty_s    = (count_r == {CW{1'b0}});
    assign full_s     = (count_r == CW'(FIFO_DEPTH));
    assign pop_s      = hit_s && (rd_off_s[1:0] == 2'd0) && !empty_s;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign push_s     = frame_ok_s && (!full_s || pop_s) && !flush_s;
    assign ovr_set_s  = frame_ok_s && full_s && !pop_s && !flush_s;

    assign dma_io_rdata       = hit_r ? rdata_r : dma_io_rdata_in;
    assign rx_interrupt_1shot = irq_1shot_r;
    assign rx_irq             = ctrl_ie_r & ~empty_s;

    // Two-stage synchroniser plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Receiver FSM: samples each bit at mid-period using the divisor latched at the start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 16'd0;
            div_lat_r <= 16'd4;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
`ifdef UART_RX_PARITY_EN
            par_err_r <= 1'b0;
`endif
        end else if (!ctrl_en_r) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (fall_s) begin
                        cnt_r     <= div_eff_s >> 1;
                        div_lat_r <= div_eff_s;
                        state_r   <= ST_START;
`ifdef UART_RX_PARITY_EN
                        par_err_r <= 1'b0;
`endif
                    end
                end
                ST_START: begin
                    if (cnt_r != 16'd0) begin
                        cnt_r <= cnt_r - 16'd1;
                    end else if (!rx_sync_r) begin
                        cnt_r     <= div_lat_r - 16'd1;
                        bit_idx_r <= 3'd0;
                        state_r   <= ST_DATA;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (cnt_r != 16'd0) begin
                        cnt_r <= cnt_r - 16'd1;
                    end else begin
                        shift_r <= {rx_sync_r, shift_r[7:1]};
                        cnt_r   <= div_lat_r - 16'd1;
                        if (bit_idx_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_r <= ctrl_pen_r ? ST_PARITY : ST_STOP;
`else
                            state_r <= ST_STOP;
`endif
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt_r != 16'd0) begin
                        cnt_r <= cnt_r - 16'd1;
                    end else begin
                        par_err_r <= (rx_sync_r != parity_bit(shift_r, ctrl_odd_r));
                        cnt_r     <= div_lat_r - 16'd1;
                        state_r   <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (cnt_r != 16'd0) begin
                        cnt_r <= cnt_r - 16'd1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Control and divisor registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_en_r <= 1'b0;
            ctrl_ie_r <= 1'b0;
            div_r     <= DIV_RESET;
`ifdef UART_RX_PARITY_EN
            ctrl_pen_r <= 1'b0;
            ctrl_odd_r <= 1'b0;
`endif
        end else begin
            if (ctrl_wr_s) begin
                ctrl_en_r <= dma_io_wdata[0];
                ctrl_ie_r <= dma_io_wdata[1];
`ifdef UART_RX_PARITY_EN
                ctrl_pen_r <= dma_io_wdata[2];
                ctrl_odd_r <= dma_io_wdata[3];
`endif
            end
            if (div_wr_s) begin
                div_r <= dma_io_wdata[15:0];
            end
        end
    end

    // Sticky error flags; a new error in the clearing cycle survives the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_r  <= 1'b0;
            ferr_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_r <= 1'b0;
`endif
        end else begin
            if (clr_s) begin
                ovr_r  <= 1'b0;
                ferr_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
                perr_r <= 1'b0;
`endif
            end
            if (ovr_set_s)  ovr_r  <= 1'b1;
            if (ferr_set_s) ferr_r <= 1'b1;
`ifdef UART_RX_PARITY_EN
            if (perr_set_s) perr_r <= 1'b1;
`endif
        end
    end

    // FIFO pointers and occupancy; flush overrides any push or pop.
    always_ff @(posedge clk) begin
        if (rst || flush_s) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            if (push_s && !pop_s)      count_r <= count_r + CW'(1);
            else if (pop_s && !push_s) count_r <= count_r - CW'(1);
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wr_ptr_r] <= shift_r;
    end

    // Register read mux, evaluated in the strobe cycle.
    always_comb begin
        rd_val_s = 32'd0;
        case (rd_off_s[1:0])
            2'd0:    rd_val_s = empty_s ? 32'd0 : {23'd0, 1'b1, mem_r[rd_ptr_r]};
            2'd1:    rd_val_s = {16'd0, 8'(count_r), 3'd0, perr_s, ferr_r, ovr_r, full_s, empty_s};
            2'd2:    rd_val_s = {28'd0, ctrl_par_s, ctrl_ie_r, ctrl_en_r};
            2'd3:    rd_val_s = {16'd0, div_r};
            default: rd_val_s = 32'd0;
        endcase
    end

    // Registered read data and interrupt pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_r       <= 1'b0;
            rdata_r     <= 32'd0;
            irq_1shot_r <= 1'b0;
        end else begin
            hit_r       <= hit_s;
            rdata_r     <= rd_val_s;
            irq_1shot_r <= push_s & ctrl_ie_r;
        end
    end
endmodule

// File: tb/tb_io_uart_in.sv
// Self-checking bench for io_uart_in: directed and random frames checked against a queue-based model.
`timescale 1ns/1ps
module tb_io_uart_in;
    localparam logic [13:0] BASE  = 14'h0300;
    localparam int          DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst, rx, we, radr_en, irq1, irq;
    logic [13:0] wadr, radr;
    logic [31:0] wdata, rdata_in, rdata, cap_val, v;

    int n_asserts = 0, n_fail = 0, pulse_cnt = 0, exp_pulses = 0, div_tb = 16;
    logic [7:0] mq[$];
    logic m_ovr = 1'b0, m_ferr = 1'b0, m_perr = 1'b0;

    io_uart_in #(.BASE_ADR(BASE), .FIFO_DEPTH(DEPTH), .DIV_RESET(16'd434)) dut (
        .clk(clk), .rst(rst), .rx(rx), .dma_io_we(we), .dma_io_wadr(wadr), .dma_io_wdata(wdata),
        .dma_io_radr(radr), .dma_io_radr_en(radr_en), .dma_io_rdata_in(rdata_in),
        .dma_io_rdata(rdata), .rx_interrupt_1shot(irq1), .rx_irq(irq));

    always #5 clk = ~clk;

    always @(negedge clk) if (irq1 === 1'b1) pulse_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic reg_write(input int off, input logic [31:0] d);
        wadr = BASE + 14'(off); wdata = d; we = 1'b1;
        tick(1);
        we = 1'b0;
    endtask

    task automatic reg_read(input int off, output logic [31:0] d);
        radr = BASE + 14'(off); radr_en = 1'b1;
        tick(1);
        radr_en = 1'b0;
        d = rdata;
    endtask

    function automatic logic [31:0] exp_status();
        return {16'd0, 8'(mq.size()), 3'd0, m_perr, m_ferr, m_ovr, (mq.size() == DEPTH), (mq.size() == 0)};
    endfunction

    function automatic void model_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok);
        if (!stop_ok) m_ferr = 1'b1;
        if (!par_ok)  m_perr = 1'b1;
        if (stop_ok && par_ok) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(d);
                exp_pulses++;
            end else begin
                m_ovr = 1'b1;
            end
        end
    endfunction

    function automatic logic [31:0] model_read();
        if (mq.size() == 0) return 32'd0;
        return {23'd0, 1'b1, mq.pop_front()};
    endfunction

    // Drives one frame (start, 8 data LSB first, optional parity, stop) at div_tb clocks per bit.
    // A DATA read is issued in iteration rd_at; its result is captured in cap_val.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int par, input int rd_at);
        int nb = (par >= 0) ? 11 : 10;
        for (int k = 0; k < nb * div_tb; k++) begin
            int bp = k / div_tb;
            if (bp == 0)                    rx = 1'b0;
            else if (bp <= 8)               rx = d[bp-1];
            else if (par >= 0 && bp == 9)   rx = (par == 1);
            else                            rx = stop;
            if (k == rd_at + 1) cap_val = rdata;
            radr = BASE;
            radr_en = (k == rd_at);
            tick(1);
        end
        rx = 1'b1; radr_en = 1'b0;
        tick(6);
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_frame(d, 1'b1, -1, -1);
        model_frame(d, 1'b1, 1'b1);
    endtask

    task automatic drain_and_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] e = model_read();
            reg_read(0, v);
            check(tag, v, e);
        end
    endtask

    initial begin
        int n;
        logic [7:0] b;
        rst = 1'b1; rx = 1'b1; we = 1'b0; radr_en = 1'b0; wadr = 14'd0; radr = 14'd0;
        wdata = 32'd0; rdata_in = 32'hdeadbeef; cap_val = 32'd0;
        tick(3);
        rst = 1'b0;
        tick(1);

        // Reset state and pass-through
        check("rst_passthru", rdata, 32'hdeadbeef);
        check("rst_1shot", {31'd0, irq1}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        reg_read(1, v); check("rst_status", v, 32'h0000_0001);
        reg_read(3, v); check("rst_div", v, 32'd434);
        reg_read(2, v); check("rst_ctrl", v, 32'd0);
        rdata_in = $urandom;
        tick(1);
        check("passthru_rand", rdata, rdata_in);
        rdata_in = 32'hdeadbeef;

        // Two bytes at DIV=16
        reg_write(3, 32'd16); reg_write(2, 32'h3); div_tb = 16;
        send_byte(8'hA5); send_byte(8'h3C);
        check("two_pulses", pulse_cnt, exp_pulses);
        check("two_irq", {31'd0, irq}, 32'd1);
        reg_read(1, v); check("two_status", v, exp_status());
        reg_read(0, v); check("two_data0", v, 32'h1A5);
        reg_read(0, v); check("two_data1", v, 32'h13C);
        reg_read(0, v); check("two_empty_rd", v, 32'd0);
        void'(model_read()); void'(model_read());
        reg_read(1, v); check("two_status_after", v, exp_status());
        check("two_irq_low", {31'd0, irq}, 32'd0);

        // Overrun: 17 bytes into a 16-deep FIFO
        for (int i = 0; i <= 16; i++) send_byte(8'(i));
        reg_read(1, v); check("ovr_status", v, exp_status());
        check("ovr_pulses", pulse_cnt, exp_pulses);
        drain_and_check("ovr_drain", 16);
        reg_write(2, 32'h103); m_ovr = 1'b0;
        reg_read(1, v); check("ovr_cleared", v, exp_status());

        // Framing error then a short glitch
        send_frame(8'h55, 1'b0, -1, -1); model_frame(8'h55, 1'b0, 1'b1);
        reg_read(1, v); check("ferr_status", v, exp_status());
        check("ferr_pulses", pulse_cnt, exp_pulses);
        reg_write(2, 32'h103); m_ferr = 1'b0;
        rx = 1'b0; tick(4); rx = 1'b1; tick(3 * div_tb);
        reg_read(1, v); check("glitch_status", v, exp_status());
        check("glitch_pulses", pulse_cnt, exp_pulses);

        // Pop in the same cycle as a push into a full FIFO
        for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom));
        // synchroniser, edge detect, half-bit countdown, then 9 full bit periods to the stop sample
        send_frame(8'hEE, 1'b1, -1, 3 + div_tb / 2 + 9 * div_tb);
        check("same_cyc_rd", cap_val, model_read());
        model_frame(8'hEE, 1'b1, 1'b1);
        reg_read(1, v); check("same_cyc_status", v, exp_status());
        check("same_cyc_pulses", pulse_cnt, exp_pulses);
        drain_and_check("same_cyc_drain", DEPTH);

        // Disable mid-byte, re-enable and receive cleanly
        rx = 1'b0; tick(4 * div_tb);
        reg_write(2, 32'h2);
        rx = 1'b1; tick(2 * div_tb);
        reg_write(2, 32'h3);
        send_byte(8'h81);
        reg_read(1, v); check("en_status", v, exp_status());
        drain_and_check("en_data", 1);

        // Random divisors and bursts
        for (int r = 0; r < 3; r++) begin
            div_tb = $urandom_range(5, 24);
            reg_write(3, 32'(div_tb));
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) send_byte(8'($urandom));
            reg_read(1, v); check("rand_status", v, exp_status());
            drain_and_check("rand_data", n + 1);
        end

        // Divisor below 4 behaves as 4
        reg_write(3, 32'd2); div_tb = 4;
        reg_read(3, v); check("div_small_rd", v, 32'd2);
        b = 8'($urandom);
        send_byte(b);
        drain_and_check("div_small_data", 1);
        check("rand_pulses", pulse_cnt, exp_pulses);

`ifdef UART_RX_PARITY_EN
        reg_write(3, 32'd16); div_tb = 16;
        reg_write(2, 32'h7);
        reg_read(2, v); check("par_ctrl", v, 32'h7);
        b = 8'h5A;
        send_frame(b, 1'b1, (^b) ? 0 : 1, -1); model_frame(b, 1'b1, 1'b0);
        reg_read(1, v); check("perr_status", v, exp_status());
        check("perr_pulses", pulse_cnt, exp_pulses);
        reg_write(2, 32'h10F); m_perr = 1'b0;
        b = 8'($urandom);
        send_frame(b, 1'b1, (^b) ? 0 : 1, -1); model_frame(b, 1'b1, 1'b1);
        reg_read(1, v); check("podd_status", v, exp_status());
        drain_and_check("podd_data", 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
